// File: rtl/edp_muldiv_seq_if.sv
`default_nettype none
// ============================================================================
// Module      : edp_muldiv_seq_if
// Description : Control bundle between the multiply/divide microsequencer and
//               the EDP control-field muxes / microcode dispatch.
// Revision    : 1.0 - initial release
// ============================================================================
interface edp_muldiv_seq_if;
   logic       start;
   logic       opDiv;
   logic       abort;
   logic       mq35;
   logic       adSign;
   logic       busy;
   logic       done;
   logic       noDivide;
   logic [5:0] adFunc;
   logic [1:0] adaSel;
   logic [1:0] adbSel;
   logic       arClr;
   logic       arLoad;
   logic [1:0] arShift;
   logic [1:0] mqShift;
   logic       qBit;

   modport slave (
      input  start, opDiv, abort, mq35, adSign,
      output busy, done, noDivide, adFunc, adaSel, adbSel,
             arClr, arLoad, arShift, mqShift, qBit
   );

   modport master (
      output start, opDiv, abort, mq35, adSign,
      input  busy, done, noDivide, adFunc, adaSel, adbSel,
             arClr, arLoad, arShift, mqShift, qBit
   );
endinterface
`default_nettype wire

// File: rtl/edp_muldiv_seq.sv
`default_nettype none
// ============================================================================
// Module      : edp_muldiv_seq
// Description : Iterative signed multiply (1-bit Booth) / non-restoring divide
//               sequencer driving the EDP AD/AR/MQ control fields while busy.
// Revision    : 1.0 - initial release
// ============================================================================
module edp_muldiv_seq #(
   parameter int STEPS = 36,
   parameter int CNT_W = 6
) (
   input  wire logic       eboxClk,
   input  wire logic       eboxReset,
   edp_muldiv_seq_if.slave bus
);

   localparam logic [5:0] C_AD_ADD   = 6'o06;
   localparam logic [5:0] C_AD_SUB   = 6'o51;
   localparam logic [5:0] C_AD_A     = 6'o37;
   localparam logic [1:0] C_AR_HOLD  = 2'b00;
   localparam logic [1:0] C_AR_HALF  = 2'b01;
   localparam logic [1:0] C_AR_DBL   = 2'b10;
   localparam logic [1:0] C_MQ_HOLD  = 2'b11;
   localparam logic [1:0] C_MQ_SHR   = 2'b10;
   localparam logic [1:0] C_MQ_SHL   = 2'b01;
   localparam logic [CNT_W-1:0] C_CNT_INIT = CNT_W'(STEPS - 1);

   typedef enum logic [2:0] {
      S_IDLE  = 3'd0,
      S_SETUP = 3'd1,
      S_STEP  = 3'd2,
      S_FIXUP = 3'd3,
      S_DONE  = 3'd4
   } state_t;

   state_t           r_state;
   logic             r_opDiv;
   logic             r_boothPrev;
   logic             r_qPrev;
   logic             r_busy;
   logic             r_done;
   logic             r_noDivide;
   logic [CNT_W-1:0] r_cnt;

   logic             w_firstStep;
   logic             w_lastStep;
   logic             w_overflow;
   logic [5:0]       w_adFunc;
   logic             w_arClr;
   logic             w_arLoad;
   logic [1:0]       w_arShift;
   logic [1:0]       w_mqShift;
   logic             w_qBit;

   assign w_firstStep = (r_cnt == C_CNT_INIT);
   assign w_lastStep  = (r_cnt == '0);
   // A non-negative first partial remainder means the quotient cannot fit.
   assign w_overflow  = (r_state == S_STEP) && r_opDiv && w_firstStep && !bus.adSign;

   // Kept separate from the strobes so the AD function never depends on adSign.
   always_comb begin
      w_adFunc = C_AD_A;
      if (!bus.abort) begin
         case (r_state)
            S_STEP: begin
               if (r_opDiv) begin
                  w_adFunc = r_qPrev ? C_AD_SUB : C_AD_ADD;
               end else begin
                  case ({bus.mq35, r_boothPrev})
                     2'b10:   w_adFunc = C_AD_SUB;
                     2'b01:   w_adFunc = C_AD_ADD;
                     default: w_adFunc = C_AD_A;
                  endcase
               end
            end
            S_FIXUP: w_adFunc = C_AD_ADD;
            default: w_adFunc = C_AD_A;
         endcase
      end
   end

   always_comb begin
      w_arClr   = 1'b0;
      w_arLoad  = 1'b0;
      w_arShift = C_AR_HOLD;
      w_mqShift = C_MQ_HOLD;
      w_qBit    = 1'b0;
      if (!bus.abort) begin
         case (r_state)
            S_SETUP: w_arClr = !r_opDiv;
            S_STEP: begin
               if (!r_opDiv) begin
                  w_arLoad  = 1'b1;
                  w_arShift = C_AR_HALF;
                  w_mqShift = C_MQ_SHR;
               end else if (!w_overflow) begin
                  w_arLoad  = 1'b1;
                  w_arShift = C_AR_DBL;
                  w_mqShift = C_MQ_SHL;
                  w_qBit    = !bus.adSign;
               end
            end
            S_FIXUP: w_arLoad = 1'b1;
            default: w_arLoad = 1'b0;
         endcase
      end
   end

   always_ff @(posedge eboxClk) begin
      if (eboxReset || bus.abort) begin
         r_state     <= S_IDLE;
         r_opDiv     <= 1'b0;
         r_boothPrev <= 1'b0;
         r_qPrev     <= 1'b0;
         r_busy      <= 1'b0;
         r_done      <= 1'b0;
         r_noDivide  <= 1'b0;
         r_cnt       <= '0;
      end else begin
         case (r_state)
            S_IDLE: begin
               r_done <= 1'b0;
               if (bus.start) begin
                  r_opDiv <= bus.opDiv;
                  r_busy  <= 1'b1;
                  r_state <= S_SETUP;
               end
            end
            S_SETUP: begin
               r_cnt      <= C_CNT_INIT;
               r_noDivide <= 1'b0;
               if (r_opDiv) begin
                  r_qPrev <= 1'b1;
               end else begin
                  r_boothPrev <= 1'b0;
               end
               r_state <= S_STEP;
            end
            S_STEP: begin
               if (r_opDiv && w_overflow) begin
                  r_noDivide <= 1'b1;
                  r_done     <= 1'b1;
                  r_state    <= S_DONE;
               end else if (r_opDiv) begin
                  r_qPrev <= !bus.adSign;
                  if (w_lastStep) begin
                     // A negative final remainder needs one restoring add.
                     r_done  <= !bus.adSign;
                     r_state <= bus.adSign ? S_FIXUP : S_DONE;
                  end else begin
                     r_cnt <= r_cnt - CNT_W'(1);
                  end
               end else begin
                  r_boothPrev <= bus.mq35;
                  if (w_lastStep) begin
                     r_done  <= 1'b1;
                     r_state <= S_DONE;
                  end else begin
                     r_cnt <= r_cnt - CNT_W'(1);
                  end
               end
            end
            S_FIXUP: begin
               r_done  <= 1'b1;
               r_state <= S_DONE;
            end
            S_DONE: begin
               r_done  <= 1'b0;
               r_busy  <= 1'b0;
               r_state <= S_IDLE;
            end
            default: begin
               r_busy  <= 1'b0;
               r_done  <= 1'b0;
               r_state <= S_IDLE;
            end
         endcase
      end
   end

   assign bus.busy     = r_busy;
   assign bus.done     = r_done;
   assign bus.noDivide = r_noDivide;
   assign bus.adFunc   = w_adFunc;
   assign bus.adaSel   = 2'b00;
   assign bus.adbSel   = 2'b10;
   assign bus.arClr    = w_arClr;
   assign bus.arLoad   = w_arLoad;
   assign bus.arShift  = w_arShift;
   assign bus.mqShift  = w_mqShift;
   assign bus.qBit     = w_qBit;

endmodule
`default_nettype wire

// File: tb/tb_edp_muldiv_seq.sv
`default_nettype none
// ============================================================================
// Module      : tb_edp_muldiv_seq
// Description : Directed bench for edp_muldiv_seq with a small AR/MQ/BR model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_edp_muldiv_seq;

   logic eboxClk = 1'b0;
   logic eboxReset;

   edp_muldiv_seq_if bus();

   edp_muldiv_seq #(.STEPS(36), .CNT_W(6)) dut (
      .eboxClk   (eboxClk),
      .eboxReset (eboxReset),
      .bus       (bus)
   );

   always #5 eboxClk = ~eboxClk;

   logic [35:0] ar = '0, mq = '0, br = '0;
   logic        div_mode = 1'b0;
   int          div_steps = 0;
   logic [35:0] a_in, ad;
   logic        ld_en;
   logic [35:0] ld_ar, ld_mq, ld_br;
   logic        ld_dv;

   // The divide doubling of AR (with MQ[0] entering the low bit) is applied
   // on the adder A input, so AR always holds the current partial remainder.
   always_comb begin
      a_in = ar;
      if (div_mode && div_steps < 36) a_in = {ar[34:0], mq[35]};
      case (bus.adFunc)
         6'o06:   ad = a_in + br;
         6'o51:   ad = a_in - br;
         default: ad = a_in;
      endcase
   end

   assign bus.mq35   = mq[0];
   assign bus.adSign = ad[35];

   always @(posedge eboxClk) begin
      if (ld_en) begin
         ar        <= ld_ar;
         mq        <= ld_mq;
         br        <= ld_br;
         div_mode  <= ld_dv;
         div_steps <= 0;
      end else begin
         if (bus.arClr)       ar <= '0;
         else if (bus.arLoad) ar <= (bus.arShift == 2'b01) ? {ad[35], ad[35:1]} : ad;
         case (bus.mqShift)
            2'b10:   mq <= {ad[0], mq[35:1]};
            2'b01:   mq <= {mq[34:0], bus.qBit};
            default: mq <= mq;
         endcase
         if (bus.arLoad && bus.arShift == 2'b10) div_steps <= div_steps + 1;
      end
   end

   int n_checks = 0;
   int n_pass   = 0;

   int          obs_done_cyc, obs_done_cnt;
   logic        obs_saw_load, obs_saw_fixup, obs_abort_strobe, obs_busy_after;
   logic [5:0]  obs_f2, obs_f3;

   task automatic run_op(input logic dv, input logic [35:0] a0, m0, b0,
                         input int abort_at, input int restart_at);
      @(negedge eboxClk);
      ld_ar = a0; ld_mq = m0; ld_br = b0; ld_dv = dv; ld_en = 1'b1;
      @(negedge eboxClk);
      ld_en = 1'b0;
      bus.start = 1'b1;
      bus.opDiv = dv;
      obs_done_cyc = -1; obs_done_cnt = 0; obs_saw_load = 1'b0; obs_saw_fixup = 1'b0;
      obs_abort_strobe = 1'b0; obs_busy_after = 1'b1; obs_f2 = '0; obs_f3 = '0;
      for (int cyc = 1; cyc <= 45; cyc++) begin
         @(negedge eboxClk);
         bus.start = (cyc == restart_at);
         bus.opDiv = (cyc == restart_at) ? ~dv : 1'b0;
         bus.abort = (cyc == abort_at);
         #1;
         if (bus.arLoad) obs_saw_load = 1'b1;
         if (bus.arLoad && bus.arShift == 2'b00 && bus.adFunc == 6'o06) obs_saw_fixup = 1'b1;
         if (cyc == 2) obs_f2 = bus.adFunc;
         if (cyc == 3) obs_f3 = bus.adFunc;
         if (cyc == abort_at)
            obs_abort_strobe = bus.arLoad | bus.arClr | (bus.mqShift != 2'b11) | (bus.arShift != 2'b00);
         if (cyc == abort_at + 1) obs_busy_after = bus.busy;
         if (bus.done) begin
            obs_done_cnt++;
            if (obs_done_cyc < 0) obs_done_cyc = cyc;
         end
      end
      bus.abort = 1'b0;
      bus.start = 1'b0;
   endtask

   task automatic test_reset();
      eboxReset = 1'b1;
      repeat (2) @(posedge eboxClk);
      @(negedge eboxClk);
      eboxReset = 1'b0;
      #1;
      n_checks++; if (bus.busy !== 1'b0) $display("FAIL reset_busy: got %b want 0", bus.busy); else n_pass++;
      n_checks++; if (bus.done !== 1'b0) $display("FAIL reset_done: got %b want 0", bus.done); else n_pass++;
      n_checks++; if (bus.adFunc !== 6'o37) $display("FAIL reset_adFunc: got %o want 37", bus.adFunc); else n_pass++;
      n_checks++; if (bus.mqShift !== 2'b11) $display("FAIL reset_mqShift: got %b want 11", bus.mqShift); else n_pass++;
      n_checks++; if ({bus.arLoad, bus.arClr} !== 2'b00) $display("FAIL reset_ar_strobes: got %b want 00", {bus.arLoad, bus.arClr}); else n_pass++;
      n_checks++; if (bus.arShift !== 2'b00) $display("FAIL reset_arShift: got %b want 00", bus.arShift); else n_pass++;
      n_checks++; if (bus.noDivide !== 1'b0) $display("FAIL reset_noDivide: got %b want 0", bus.noDivide); else n_pass++;
   endtask

   task automatic test_mul_pos();
      run_op(1'b0, 36'o777, 36'd5, 36'd3, -1, -1);
      n_checks++; if (obs_done_cyc !== 38) $display("FAIL mul_pos_latency: got %0d want 38", obs_done_cyc); else n_pass++;
      n_checks++; if (ar !== 36'd0) $display("FAIL mul_pos_ar: got %o want 0", ar); else n_pass++;
      n_checks++; if (mq !== 36'd15) $display("FAIL mul_pos_mq: got %o want 17", mq); else n_pass++;
      n_checks++; if (obs_f2 !== 6'o51) $display("FAIL mul_pos_step0: got %o want 51", obs_f2); else n_pass++;
      n_checks++; if (obs_f3 !== 6'o06) $display("FAIL mul_pos_step1: got %o want 06", obs_f3); else n_pass++;
      n_checks++; if (obs_done_cnt !== 1) $display("FAIL mul_pos_done_pulses: got %0d want 1", obs_done_cnt); else n_pass++;
   endtask

   task automatic test_mul_neg();
      run_op(1'b0, 36'd0, 36'd5, 36'o777777777775, -1, -1);
      n_checks++; if (obs_done_cyc !== 38) $display("FAIL mul_neg_latency: got %0d want 38", obs_done_cyc); else n_pass++;
      n_checks++; if (ar !== 36'o777777777777) $display("FAIL mul_neg_ar: got %o want 777777777777", ar); else n_pass++;
      n_checks++; if (mq !== 36'o777777777761) $display("FAIL mul_neg_mq: got %o want 777777777761", mq); else n_pass++;
      n_checks++; if (bus.noDivide !== 1'b0) $display("FAIL mul_neg_noDivide: got %b want 0", bus.noDivide); else n_pass++;
   endtask

   task automatic test_div();
      run_op(1'b1, 36'd0, 36'd100, 36'd7, -1, -1);
      n_checks++; if (obs_done_cyc !== 39) $display("FAIL div_latency: got %0d want 39", obs_done_cyc); else n_pass++;
      n_checks++; if (obs_saw_fixup !== 1'b1) $display("FAIL div_fixup: got %b want 1", obs_saw_fixup); else n_pass++;
      n_checks++; if (mq !== 36'd14) $display("FAIL div_quotient: got %0d want 14", mq); else n_pass++;
      n_checks++; if (ar !== 36'd2) $display("FAIL div_remainder: got %0d want 2", ar); else n_pass++;
      n_checks++; if (bus.noDivide !== 1'b0) $display("FAIL div_noDivide: got %b want 0", bus.noDivide); else n_pass++;
   endtask

   task automatic test_div_overflow();
      run_op(1'b1, 36'o10, 36'd0, 36'd3, -1, -1);
      n_checks++; if (obs_done_cyc !== 3) $display("FAIL ovf_latency: got %0d want 3", obs_done_cyc); else n_pass++;
      n_checks++; if (obs_saw_load !== 1'b0) $display("FAIL ovf_arLoad: got %b want 0", obs_saw_load); else n_pass++;
      n_checks++; if (bus.noDivide !== 1'b1) $display("FAIL ovf_noDivide_sticky: got %b want 1", bus.noDivide); else n_pass++;
      n_checks++; if (ar !== 36'o10) $display("FAIL ovf_ar_kept: got %o want 10", ar); else n_pass++;
      n_checks++; if (bus.busy !== 1'b0) $display("FAIL ovf_idle: got %b want 0", bus.busy); else n_pass++;
   endtask

   task automatic test_ignored_start();
      run_op(1'b0, 36'd0, 36'd9, 36'd6, -1, 7);
      n_checks++; if (obs_done_cyc !== 38) $display("FAIL restart_latency: got %0d want 38", obs_done_cyc); else n_pass++;
      n_checks++; if (obs_done_cnt !== 1) $display("FAIL restart_done_pulses: got %0d want 1", obs_done_cnt); else n_pass++;
      n_checks++; if (mq !== 36'd54) $display("FAIL restart_mq: got %0d want 54", mq); else n_pass++;
      n_checks++; if (ar !== 36'd0) $display("FAIL restart_ar: got %o want 0", ar); else n_pass++;
      n_checks++; if (bus.noDivide !== 1'b0) $display("FAIL restart_noDivide_cleared: got %b want 0", bus.noDivide); else n_pass++;
   endtask

   task automatic test_abort();
      run_op(1'b0, 36'd0, 36'd5, 36'd3, 12, -1);
      n_checks++; if (obs_abort_strobe !== 1'b0) $display("FAIL abort_strobes_forced: got %b want 0", obs_abort_strobe); else n_pass++;
      n_checks++; if (obs_busy_after !== 1'b0) $display("FAIL abort_busy: got %b want 0", obs_busy_after); else n_pass++;
      n_checks++; if (obs_done_cnt !== 0) $display("FAIL abort_done_pulses: got %0d want 0", obs_done_cnt); else n_pass++;
   endtask

   initial begin
      bus.start = 1'b0;
      bus.opDiv = 1'b0;
      bus.abort = 1'b0;
      ld_en = 1'b0; ld_ar = '0; ld_mq = '0; ld_br = '0; ld_dv = 1'b0;
      test_reset();
      test_mul_pos();
      test_mul_neg();
      test_div();
      test_div_overflow();
      test_ignored_start();
      test_abort();
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
`default_nettype wire

// File: doc/edp_muldiv_seq.md
Name: edp_muldiv_seq

Overview:
Microsequencer that drives the EDP AD/AR/ARX/MQ control fields through iterative signed multiply (1-bit Booth) and non-restoring divide. It lives in ebox beside edp and feeds its per-cycle outputs into the CTL/CRAM control field muxes in place of microcode while busy. Operands are already in EDP registers when it starts: multiplicand or divisor in BR, multiplier or low dividend in MQ, high dividend in AR. It reports done and no-divide to the microcode dispatch.

Parameters:
STEPS, 36, iteration count (word width)
CNT_W, 6, step counter width (ceil log2 STEPS)

Ports:
eboxClk  input  1  EBOX clock
eboxReset  input  1  synchronous active-high reset
start  input  1  one-cycle request; sampled only in IDLE
opDiv  input  1  sampled with start: 0=multiply, 1=divide
abort  input  1  cancel operation (page fail/interrupt)
mq35  input  1  EDP_MQ[35] (Booth multiplier bit)
adSign  input  1  EDP_AD[0] of the current-cycle AD result
busy  output  1  sequencer owns EDP control fields
done  output  1  one-cycle completion pulse
noDivide  output  1  sticky divide-overflow flag
adFunc  output  6  CRAM_AD code: 06 (A+B), 51 (A-B), 37 (A); octal
adaSel  output  2  00=AR
adbSel  output  2  10=BR
arClr  output  1  clear AR (all halves)
arLoad  output  1  load ARL and ARR
arShift  output  2  00 hold, 01 AD*0.5 into AR and AD[35] into ARX[0], 10 AD*2 with ARX[0] into AD[35]
mqShift  output  2  USR code: 11 hold, 10 SHR, 01 SHL
qBit  output  1  quotient bit shifted into MQ[35] on SHL

Behaviour:
- Reset, or abort in any state: next state IDLE; busy=0, done=0, noDivide=0, counter=0, Booth prev bit=0. All control outputs take idle values: adFunc=37, arLoad=0, arClr=0, arShift=00, mqShift=11, qBit=0. In the cycle abort is high, all strobes are combinationally forced to idle values, so no register is written.
- States are IDLE, SETUP, STEP, FIXUP, DONE. busy=1 in every state except IDLE.
- IDLE: on start, latch opDiv and go to SETUP. start is ignored in any other state.
- SETUP (1 cycle):
  - Multiply: arClr=1, prev:=0.
  - Divide: no strobe; qPrev:=1, which forces a subtract on the first step.
  - Both: counter:=STEPS-1; noDivide:=0.
- STEP, multiply: action is chosen from {mq35, prev}.
  - 00 or 11: adFunc=37.
  - 10: adFunc=51.
  - 01: adFunc=06.
  - Every step: arLoad=1, arShift=01, mqShift=10 (ARX[35] enters MQ[0]), prev:=mq35.
- STEP, divide:
  - adFunc=51 if qPrev=1, else 06.
  - arLoad=1, arShift=10, mqShift=01, qBit=~adSign, qPrev:=~adSign.
  - First step only: if adSign=0, set noDivide=1, suppress that cycle's strobes, and go to DONE.
- Counter decrements each STEP. When counter=0 at the end of a step:
  - Multiply goes to DONE.
  - Divide goes to FIXUP if the last adSign=1, else to DONE.
- FIXUP (divide only, 1 cycle): adFunc=06, arLoad=1, arShift=00 (restore remainder), mqShift=11. Then DONE.
- DONE (1 cycle): done=1, strobes idle, then IDLE. noDivide holds until the next SETUP or reset.
- Latency from the start edge to done high:
  - Multiply: STEPS+2 = 38 cycles.
  - Divide: 38 cycles, or 39 with fixup.
  - Overflow: 3 cycles.
- Counter never wraps. Underflow is impossible because the exit is taken at 0.

Test Plan:
- Reset then idle: after eboxReset for 2 cycles, expect busy=0, done=0, adFunc=37, mqShift=11, and every load strobe 0.
- Multiply 3*5: BR=3, MQ=5, pulse start with opDiv=0. Expect done exactly 38 cycles later; AR,MQ=0,15. Step 0 adFunc=51 and step 1 adFunc=06.
- Multiply -3*5 (BR=777777777775 octal): AR=777777777777 and MQ=777777777761 (octal) at done. noDivide=0.
- Divide 100/7: AR=0, MQ=100, BR=7. Expect done at 39 cycles with FIXUP visited; MQ=14 and AR=2.
- Divide overflow: AR=10, BR=3. Expect noDivide=1 and done 3 cycles after start, with no arLoad pulse.
- Abort and ignored start:
  - Assert abort at step 10: next cycle busy=0, and done is never pulsed.
  - Issue a second start at step 5 of a multiply: it is ignored, and the result matches the single-op run.
